// File: rtl/dmem_bus_bridge.sv
// MEM-stage data-memory bridge: turns core load/store strobes into a req/ack bus
// transaction and holds the pipeline in stall until the access completes or aborts.
module dmem_bus_bridge #(
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_memread,
    input  logic        cpu_memwrite,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    input  logic        err_clr,
    output logic [1:0]  err_code,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] cnt;
    logic       access;
    logic       aligned;

    // Bus handshake: bus_req rises with address/we/wdata already valid and holds them
    // unchanged until the single-cycle bus_ack is sampled (or the timeout abort fires);
    // bus_ack is only meaningful while bus_req is high and is ignored otherwise.
    assign access    = cpu_memread | cpu_memwrite;
    assign aligned   = (cpu_addr[1:0] == 2'b00);
    assign stall     = reset & (((state == IDLE) & access) | (state == REQ));
    assign dbg_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_wdata <= 32'd0;
            cpu_rdata <= 32'd0;
            err_code  <= 2'b00;
        end else begin
            // Any error set later in this block overrides the clear.
            if (err_clr) err_code <= 2'b00;
            case (state)
                IDLE: begin
                    if (access) begin
                        if (aligned) begin
                            bus_addr  <= {cpu_addr[31:2], 2'b00};
                            bus_wdata <= cpu_wdata;
                            bus_we    <= cpu_memwrite;
                            bus_req   <= 1'b1;
                            cnt       <= 8'd0;
                            state     <= REQ;
                        end else begin
                            err_code <= 2'b01;
                            if (!cpu_memwrite) cpu_rdata <= ERR_DATA;
                            state    <= DONE;
                        end
                    end
                end
                REQ: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (!bus_we) cpu_rdata <= bus_rdata;
                        state   <= DONE;
                    end else if (cnt == LAST_CNT) begin
                        bus_req  <= 1'b0;
                        err_code <= 2'b10;
                        if (!bus_we) cpu_rdata <= ERR_DATA;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                // One unstalled cycle so the pipeline moves past the access before
                // the strobes are looked at again.
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Randomized bench for dmem_bus_bridge: a transaction-level model predicts stall
// length, bus occupancy, load data and error code for every access.
module tb_dmem_bus_bridge;

    localparam int          TIMEOUT  = 16;
    localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

    logic        clk;
    logic        reset;
    logic        cpu_memread;
    logic        cpu_memwrite;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        stall;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        err_clr;
    logic [1:0]  err_code;
    logic [1:0]  dbg_state;

    dmem_bus_bridge #(.TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_memread  (cpu_memread),
        .cpu_memwrite (cpu_memwrite),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .stall        (stall),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_ack      (bus_ack),
        .bus_rdata    (bus_rdata),
        .err_clr      (err_clr),
        .err_code     (err_code),
        .dbg_state    (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          req_starts = 0;
    logic        req_prev = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] m_rdata;
    logic [1:0]  m_err;

    always @(negedge clk) begin
        if (bus_req && !req_prev) req_starts++;
        req_prev = bus_req;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ack_at: REQ cycle (1-based) in which the bus acks; 0 or > TIMEOUT means never.
    task automatic do_access(input bit rd, input bit wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input int ack_at,
                             input logic [31:0] ack_data, input bit clr);
        int   stall_cnt = 0;
        int   req_cnt   = 0;
        int   k;
        bit   stable    = 1'b1;
        bit   done      = 1'b0;
        bit   mis;
        bit   acked;
        bit   err_set   = 1'b0;
        logic [1:0] code = 2'b00;

        mis = (addr[1:0] != 2'b00);
        if (mis) begin
            k       = 0;
            err_set = 1'b1;
            code    = 2'b01;
            if (!wr) m_rdata = ERR_DATA;
        end else begin
            acked = (ack_at >= 1) && (ack_at <= TIMEOUT);
            k     = acked ? ack_at : TIMEOUT;
            if (!acked) begin
                err_set = 1'b1;
                code    = 2'b10;
                if (!wr) m_rdata = ERR_DATA;
            end else if (!wr) begin
                m_rdata = ack_data;
            end
        end
        if (err_set) m_err = code;
        else if (clr) m_err = 2'b00;
        exp_q.push_back(m_rdata);

        @(negedge clk);
        cpu_memread  = rd;
        cpu_memwrite = wr;
        cpu_addr     = addr;
        cpu_wdata    = wdata;
        err_clr      = clr;
        for (int cyc = 0; cyc < 300; cyc++) begin
            #1;
            if (!stall) begin
                bus_ack = 1'b0;
                done    = 1'b1;
                break;
            end
            stall_cnt++;
            bus_ack   = 1'b0;
            bus_rdata = $urandom;
            if (bus_req) begin
                req_cnt++;
                if (bus_addr !== addr || bus_we !== wr || bus_wdata !== wdata) stable = 1'b0;
                if (req_cnt == ack_at) begin
                    bus_ack   = 1'b1;
                    bus_rdata = ack_data;
                end
            end
            @(negedge clk);
        end
        bus_ack = 1'b0;
        check("done_reached", 32'(done), 32'd1);
        check("stall_cycles", stall_cnt, mis ? 32'd1 : 32'(1 + k));
        check("req_cycles", req_cnt, 32'(k));
        check("bus_stable", 32'(stable), 32'd1);
        check("req_low_done", 32'(bus_req), 32'd0);
        check("rdata", cpu_rdata, exp_q.pop_front());
        check("err_code", 32'(err_code), 32'(m_err));
        err_clr = 1'b0;
    endtask

    task automatic idle_cycles(input int n, input bit spurious);
        int starts0;
        starts0 = req_starts;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cpu_memread  = 1'b0;
            cpu_memwrite = 1'b0;
            bus_ack      = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
            bus_rdata    = $urandom;
        end
        #1;
        bus_ack = 1'b0;
        check("idle_stall", 32'(stall), 32'd0);
        check("idle_rdata", cpu_rdata, m_rdata);
        check("idle_err", 32'(err_code), 32'(m_err));
        check("idle_no_req", 32'(req_starts - starts0), 32'd0);
    endtask

    task automatic clear_err();
        @(negedge clk);
        cpu_memread  = 1'b0;
        cpu_memwrite = 1'b0;
        err_clr      = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_err   = 2'b00;
        #1;
        check("err_cleared", 32'(err_code), 32'd0);
    endtask

    initial begin
        int          s0;
        int          op;
        logic [31:0] a;
        reset        = 1'b0;
        cpu_memread  = 1'b0;
        cpu_memwrite = 1'b0;
        cpu_addr     = 32'd0;
        cpu_wdata    = 32'd0;
        bus_ack      = 1'b0;
        bus_rdata    = 32'd0;
        err_clr      = 1'b0;
        m_rdata      = 32'd0;
        m_err        = 2'b00;
        repeat (3) @(negedge clk);
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_rdata", cpu_rdata, 32'd0);
        check("rst_err", 32'(err_code), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        reset = 1'b1;

        do_access(1, 0, 32'h0000_0040, $urandom, 1, 32'h1234_5678, 0);
        do_access(0, 1, 32'h0000_0100, 32'hCAFE_F00D, 3, $urandom, 0);
        do_access(1, 0, 32'h0000_0042, $urandom, 1, $urandom, 0);
        clear_err();
        do_access(1, 0, 32'h0000_0080, $urandom, 0, $urandom, 0);
        do_access(1, 0, 32'h0000_0084, $urandom, TIMEOUT, 32'h55AA_33CC, 0);

        s0 = req_starts;
        do_access(1, 0, 32'h0000_0200, $urandom, 2, 32'h0BAD_F00D, 0);
        do_access(0, 1, 32'h0000_0204, 32'h1357_9BDF, 1, $urandom, 0);
        check("b2b_two_txn", 32'(req_starts - s0), 32'd2);
        idle_cycles(6, 1);

        do_access(1, 1, 32'h0000_0300, 32'hA5A5_5A5A, 1, $urandom, 0);
        do_access(1, 0, 32'h0000_0301, $urandom, 1, $urandom, 1);
        do_access(1, 0, 32'h0000_0304, $urandom, 2, 32'h7777_0001, 1);

        // reset during REQ, with the core still asserting the access
        do_access(0, 1, 32'h0000_0013, $urandom, 1, $urandom, 0);
        @(negedge clk);
        cpu_memread  = 1'b1;
        cpu_memwrite = 1'b0;
        cpu_addr     = 32'h0000_0400;
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_req", 32'(bus_req), 32'd0);
        check("mid_rst_stall", 32'(stall), 32'd0);
        check("mid_rst_rdata", cpu_rdata, 32'd0);
        check("mid_rst_err", 32'(err_code), 32'd0);
        check("mid_rst_addr", bus_addr, 32'd0);
        m_rdata = 32'd0;
        m_err   = 2'b00;
        @(negedge clk);
        cpu_memread = 1'b0;
        bus_ack     = 1'b1;
        bus_rdata   = 32'hFFFF_0000;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        check("late_ack_state", 32'(dbg_state), 32'd0);
        check("late_ack_rdata", cpu_rdata, 32'd0);
        do_access(1, 0, 32'h0000_0500, $urandom, 2, 32'h0F0F_F0F0, 0);

        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 2);
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            do_access(op != 1, op != 0, a, $urandom, $urandom_range(0, TIMEOUT + 2),
                      $urandom, $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3), 1);
            if ($urandom_range(0, 9) == 0) clear_err();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
